// File: rtl/adder_arb_pkg.sv
// Shared types for the round-robin adder arbiter.
//   type_adder_cmd_e   : per-request operation select (ADD / SUB)
//   type_adder_flags_s : condition flags captured with each result
//   type_arb_state_e   : occupancy of the single response register
package adder_arb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned FLAG_W = 4;

    typedef enum logic {
        SUB = 1'b0,
        ADD = 1'b1
    } type_adder_cmd_e;

    typedef struct packed {
        logic z;
        logic s;
        logic o;
        logic c;
    } type_adder_flags_s;

    typedef enum logic {
        ARB_EMPTY,
        ARB_FULL
    } type_arb_state_e;

    // Port order of the flag bus is {c,z,s,o}, which differs from the struct order.
    function automatic logic [FLAG_W-1:0] pack_flags_czso(input type_adder_flags_s f);
        return {f.c, f.z, f.s, f.o};
    endfunction

endpackage

// File: rtl/adder_rr_pick.sv
// Combinational round-robin picker.
//   vld : request valids, one bit per requester
//   ptr : index where the search starts (highest priority)
//   en  : grant enable; no grant is issued while low
//   gnt : one-hot grant (or zero)
//   idx : index of the granted requester (0 when no grant)
module adder_rr_pick
    import adder_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] vld,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx
);

    localparam int unsigned SW = ID_W + 1;

    // (base + off) mod NUM_REQ; one extra bit holds the unwrapped sum.
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                                 input int unsigned     off);
        logic [SW-1:0] s;
        s = {1'b0, base} + SW'(off);
        if (s >= SW'(NUM_REQ)) begin
            s = s - SW'(NUM_REQ);
        end
        return s[ID_W-1:0];
    endfunction

    logic            found;
    logic [ID_W-1:0] cand;

    // Walk upward from ptr; the first valid requester wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = wrap_idx(ptr, i);
            if (en && !found && vld[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/adder_rr_arbiter.sv
// Shares one 32-bit adder between NUM_REQ requesters with round-robin grant
// and a single registered response stage tagged with the requester index.
// Optional feature: define ADDER_ARB_FLAGS_EN to register {c,z,s,o} flags
// with each result; otherwise rsp_flags_o is tied to zero.
//   clk, rst      : clock, synchronous active-high reset
//   req_vld_i     : per-requester valid
//   req_cmd_i     : per-requester op (1 = add, 0 = subtract)
//   req_op1_i/op2 : packed 32-bit operands, requester k at [32k+31:32k]
//   req_rdy_o     : combinational one-hot grant
//   rsp_vld_o/rdy : response handshake
//   rsp_id_o      : requester index of the response
//   rsp_res_o     : 32-bit result
//   rsp_flags_o   : {c,z,s,o}
module adder_rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_vld_i,
    input  logic [NUM_REQ-1:0]        req_cmd_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_op1_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_op2_i,
    output logic [NUM_REQ-1:0]        req_rdy_o,
    output logic                      rsp_vld_o,
    input  logic                      rsp_rdy_i,
    output logic [ID_W-1:0]           rsp_id_o,
    output logic [DATA_W-1:0]         rsp_res_o,
    output logic [FLAG_W-1:0]         rsp_flags_o
);

`ifdef ADDER_ARB_FLAGS_EN
    localparam int unsigned SUM_W = DATA_W + 1;
`else
    localparam int unsigned SUM_W = DATA_W;
`endif

    type_arb_state_e   state;
    logic [ID_W-1:0]   rr_ptr;
    logic              can_accept;
    logic              pick_en;
    logic [ID_W-1:0]   gnt_idx;
    logic              gnt_any;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    type_adder_cmd_e   cmd;
    logic [SUM_W-1:0]  sum;
    logic [DATA_W-1:0] op1_arr [NUM_REQ];
    logic [DATA_W-1:0] op2_arr [NUM_REQ];

    // Unpack the flat operand buses.
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign op1_arr[k] = req_op1_i[DATA_W*k +: DATA_W];
        assign op2_arr[k] = req_op2_i[DATA_W*k +: DATA_W];
    end

    // Drain-and-refill in the same cycle keeps throughput at one op per cycle.
    assign can_accept = (state == ARB_EMPTY) || rsp_rdy_i;
    assign pick_en    = can_accept && !rst;
    assign gnt_any    = |req_rdy_o;
    assign rsp_vld_o  = (state == ARB_FULL);

    adder_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .vld (req_vld_i),
        .ptr (rr_ptr),
        .en  (pick_en),
        .gnt (req_rdy_o),
        .idx (gnt_idx)
    );

    // Granted operand mux feeding the single shared adder.
    assign op_a = op1_arr[gnt_idx];
    assign op_b = op2_arr[gnt_idx];
    assign cmd  = type_adder_cmd_e'(req_cmd_i[gnt_idx]);

    // Zero-extended add/sub; the extra bit (when present) is carry/borrow.
    always_comb begin
        sum = '0;
        if (cmd == ADD) begin
            sum = SUM_W'(op_a) + SUM_W'(op_b);
        end else begin
            sum = SUM_W'(op_a) - SUM_W'(op_b);
        end
    end

    // Occupancy FSM, round-robin pointer and response register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_EMPTY;
            rr_ptr    <= '0;
            rsp_id_o  <= '0;
            rsp_res_o <= '0;
        end else begin
            if (gnt_any) begin
                rsp_id_o  <= gnt_idx;
                rsp_res_o <= sum[DATA_W-1:0];
                rr_ptr    <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
            end
            case (state)
                ARB_EMPTY: if (gnt_any) state <= ARB_FULL;
                ARB_FULL:  if (rsp_rdy_i && !gnt_any) state <= ARB_EMPTY;
                default:   state <= ARB_EMPTY;
            endcase
        end
    end

`ifdef ADDER_ARB_FLAGS_EN
    type_adder_flags_s flags_c;
    type_adder_flags_s flags_q;
    logic              b31_eff;

    // Overflow uses the subtract form; for add the op2 sign is inverted.
    always_comb begin
        flags_c   = '0;
        b31_eff   = (cmd == ADD) ? ~op_b[DATA_W-1] : op_b[DATA_W-1];
        flags_c.c = sum[DATA_W];
        flags_c.z = ~|sum[DATA_W-1:0];
        flags_c.s = sum[DATA_W-1];
        flags_c.o = (~op_a[DATA_W-1] &  b31_eff &  sum[DATA_W-1]) |
                    ( op_a[DATA_W-1] & ~b31_eff & ~sum[DATA_W-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
        end else if (gnt_any) begin
            flags_q <= flags_c;
        end
    end

    assign rsp_flags_o = pack_flags_czso(flags_q);
`else
    assign rsp_flags_o = '0;
`endif

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Self-checking bench for adder_rr_arbiter: vector table, directed sequences
// and a grant-to-response scoreboard.
module tb_adder_rr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned IW = 2;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_vld_i;
    logic [N-1:0]    req_cmd_i;
    logic [N*32-1:0] req_op1_i;
    logic [N*32-1:0] req_op2_i;
    logic [N-1:0]    req_rdy_o;
    logic            rsp_vld_o;
    logic            rsp_rdy_i;
    logic [IW-1:0]   rsp_id_o;
    logic [31:0]     rsp_res_o;
    logic [3:0]      rsp_flags_o;

    adder_rr_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_vld_i   (req_vld_i),
        .req_cmd_i   (req_cmd_i),
        .req_op1_i   (req_op1_i),
        .req_op2_i   (req_op2_i),
        .req_rdy_o   (req_rdy_o),
        .rsp_vld_o   (rsp_vld_o),
        .rsp_rdy_i   (rsp_rdy_i),
        .rsp_id_o    (rsp_id_o),
        .rsp_res_o   (rsp_res_o),
        .rsp_flags_o (rsp_flags_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: returns {c,z,s,o,res}; flags are zero unless the feature is built in.
    function automatic logic [35:0] model(input logic cmd, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        c, z, s, o;
        longint      sr;
        if (cmd) begin
            r  = a + b;
            c  = ({32'b0, a} + {32'b0, b}) > 64'h0000_0000_FFFF_FFFF;
            sr = longint'($signed(a)) + longint'($signed(b));
        end else begin
            r  = a - b;
            c  = (a < b);
            sr = longint'($signed(a)) - longint'($signed(b));
        end
        o = (sr != longint'($signed(r)));
        z = (r == 32'h0);
        s = r[31];
`ifndef ADDER_ARB_FLAGS_EN
        c = 1'b0; z = 1'b0; s = 1'b0; o = 1'b0;
`endif
        return {c, z, s, o, r};
    endfunction

    typedef struct {
        int          id;
        logic [35:0] exp;
    } sb_t;
    sb_t sb[$];

    // Scoreboard: pop on response handshake, push on every grant.
    always @(negedge clk) begin
        if (!rst) begin
            check("gnt_legal", {62'b0, $onehot0(req_rdy_o), ((req_rdy_o & ~req_vld_i) == '0)}, 64'd3);
            if (rsp_vld_o && rsp_rdy_i) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    check("sb_id", 64'(rsp_id_o), 64'(e.id));
                    check("sb_res_flags", {28'b0, rsp_flags_o, rsp_res_o}, 64'(e.exp));
                end
            end
            for (int k = 0; k < N; k++) begin
                if (req_rdy_o[k]) begin
                    sb_t e;
                    e.id  = k;
                    e.exp = model(req_cmd_i[k], req_op1_i[32*k +: 32], req_op2_i[32*k +: 32]);
                    sb.push_back(e);
                end
            end
        end
    end

    task automatic set_req(input int k, input logic cmd, input logic [31:0] a, input logic [31:0] b);
        req_cmd_i[k]          = cmd;
        req_op1_i[32*k +: 32] = a;
        req_op2_i[32*k +: 32] = b;
    endtask

    typedef struct {
        int          id;
        logic        cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flags;   // {c,z,s,o}
    } vec_t;
    vec_t vecs[7];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_fl;
        logic       got;

        vecs[0] = '{0, 1'b0, 32'd5,         32'd3,         32'd2,         4'b0000};
        vecs[1] = '{2, 1'b0, 32'd3,         32'd5,         32'hFFFF_FFFE, 4'b1010};
        vecs[2] = '{1, 1'b1, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 4'b0011};
        vecs[3] = '{3, 1'b1, 32'hFFFF_FFFF, 32'd1,         32'h0,         4'b1100};
        vecs[4] = '{0, 1'b0, 32'd7,         32'd7,         32'h0,         4'b0100};
        vecs[5] = '{2, 1'b0, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 4'b0001};
        vecs[6] = '{3, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0,         4'b1101};

        rst       = 1'b1;
        rsp_rdy_i = 1'b1;
        req_cmd_i = '0;
        req_op1_i = '0;
        req_op2_i = '0;
        set_req(0, 1'b1, 32'h10,        32'h1);
        set_req(1, 1'b0, 32'h100,       32'h5);
        set_req(2, 1'b1, 32'hFFFF_FFF0, 32'h20);
        set_req(3, 1'b0, 32'h0,         32'h1);
        req_vld_i = 4'b1111;

        // Reset state with all requesters valid.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rdy", 64'(req_rdy_o), 64'd0);
        check("rst_vld", 64'(rsp_vld_o), 64'd0);
        check("rst_id",  64'(rsp_id_o),  64'd0);
        check("rst_res", 64'(rsp_res_o), 64'd0);
        check("rst_flg", 64'(rsp_flags_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // All valid: grants 0,1,2,3,0 with the id trailing by one cycle.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rr_gnt", 64'(req_rdy_o), 64'(4'b0001 << (i % 4)));
            if (i > 0) check("rr_id", 64'(rsp_id_o), 64'((i - 1) % 4));
        end
        @(posedge clk); #1;
        req_vld_i = '0;
        @(negedge clk);
        check("rr_last_id", 64'(rsp_id_o), 64'd0);

        // Table of single-requester operations.
        for (int v = 0; v < 7; v++) begin
            @(posedge clk); #1;
            set_req(vecs[v].id, vecs[v].cmd, vecs[v].a, vecs[v].b);
            req_vld_i = 4'b0001 << vecs[v].id;
            got = 1'b0;
            for (int w = 0; w < 10; w++) begin
                @(negedge clk);
                if (req_rdy_o[vecs[v].id]) begin
                    got = 1'b1;
                    break;
                end
            end
            check("vec_grant", 64'(got), 64'd1);
            @(posedge clk); #1;
            req_vld_i = '0;
            @(negedge clk);
`ifdef ADDER_ARB_FLAGS_EN
            exp_fl = vecs[v].flags;
`else
            exp_fl = 4'b0;
`endif
            check("vec_vld",   64'(rsp_vld_o),   64'd1);
            check("vec_id",    64'(rsp_id_o),    64'(vecs[v].id));
            check("vec_res",   64'(rsp_res_o),   64'(vecs[v].res));
            check("vec_flags", 64'(rsp_flags_o), 64'(exp_fl));
        end

        // Backpressure: hold for 3 cycles, then drain and refill together.
        @(posedge clk); #1;
        set_req(1, 1'b1, 32'd10, 32'd20);
        set_req(2, 1'b0, 32'd100, 32'd1);
        req_vld_i = 4'b0010;
        @(negedge clk);
        check("bp_gnt1", 64'(req_rdy_o), 64'h2);
        @(posedge clk); #1;
        req_vld_i = 4'b0100;
        rsp_rdy_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_rdy", 64'(req_rdy_o), 64'd0);
            check("bp_hold_vld", 64'(rsp_vld_o), 64'd1);
            check("bp_hold_id",  64'(rsp_id_o),  64'd1);
            check("bp_hold_res", 64'(rsp_res_o), 64'd30);
            @(posedge clk); #1;
        end
        rsp_rdy_i = 1'b1;
        @(negedge clk);
        check("bp_refill_gnt", 64'(req_rdy_o), 64'h4);
        check("bp_drain_id",   64'(rsp_id_o),  64'd1);
        @(posedge clk); #1;
        req_vld_i = '0;
        @(negedge clk);
        check("bp_new_vld", 64'(rsp_vld_o), 64'd1);
        check("bp_new_id",  64'(rsp_id_o),  64'd2);
        check("bp_new_res", 64'(rsp_res_o), 64'd99);

        // Reset while FULL with requests pending: response dropped, pointer cleared.
        @(posedge clk); #1;
        set_req(1, 1'b1, 32'd50, 32'd8);
        set_req(0, 1'b1, 32'd1,  32'd2);
        req_vld_i = 4'b0010;
        @(negedge clk);
        check("rst_full_gnt", 64'(req_rdy_o), 64'h2);
        @(posedge clk); #1;
        req_vld_i = 4'b1111;
        rsp_rdy_i = 1'b0;
        rst       = 1'b1;
        sb.delete();
        @(negedge clk);
        check("rst_full_rdy", 64'(req_rdy_o), 64'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        rsp_rdy_i = 1'b1;
        @(negedge clk);
        check("rst_full_vld", 64'(rsp_vld_o), 64'd0);
        check("rst_ptr_gnt",  64'(req_rdy_o), 64'h1);
        @(posedge clk); #1;
        req_vld_i = '0;
        @(negedge clk);
        check("rst_after_id",  64'(rsp_id_o),  64'd0);
        check("rst_after_res", 64'(rsp_res_o), 64'd3);

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
